// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: word/address widths, reset PC
// default and the fetch FSM state encoding.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int JIMM_W = 26;
    localparam int BOFF_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'b00,
        FS_REQ    = 2'b01,
        FS_FILLED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory read channel: one request at a time, ack carries data.
interface inst_fetch_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [XLEN-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/inst_fetch_next_pc_calc.sv
// Combinational next-PC selection: sequential, jump, or (with
// INST_FETCH_BRANCH_EN defined) taken-branch target. Jump has priority.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_jump,
    input  logic [JIMM_W-1:0] i_jump_imm,
    input  logic              i_branch_taken,
    input  logic [BOFF_W-1:0] i_branch_offset,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_jump_target;

    assign w_pc4         = i_pc + 32'd4;
    assign w_jump_target = {w_pc4[31:28], i_jump_imm, 2'b00};

`ifdef INST_FETCH_BRANCH_EN
    logic [ADDR_W-1:0] w_branch_target;

    assign w_branch_target = w_pc4 + {{(ADDR_W-BOFF_W-2){i_branch_offset[BOFF_W-1]}},
                                      i_branch_offset, 2'b00};

    always_comb begin
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_target;
        end
    end
`else
    // Branch inputs exist on the port list but drive nothing in this build.
    logic w_unused_branch;
    assign w_unused_branch = ^{i_branch_taken, i_branch_offset};

    always_comb begin
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end
    end
`endif

endmodule

// File: rtl/inst_fetch.sv
// Single-slot instruction fetch: one outstanding imem read feeding the IF/ID
// register. Optional branch redirect enabled by INST_FETCH_BRANCH_EN.
//
// state  | meaning
// IDLE   | first cycle after reset, loads fetch PC with RESET_PC
// REQ    | request held on imem until ack
// FILLED | IF/ID holds a word, waiting for downstream to consume it
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_if.master      imem,
    output logic [XLEN-1:0]   instruction,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              jump,
    input  logic [JIMM_W-1:0] jump_immediate,
    input  logic              branch_taken,
    input  logic [BOFF_W-1:0] branch_offset
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [XLEN-1:0]   r_instruction;
    logic [ADDR_W-1:0] r_pc_out;
    logic              r_inst_valid;

    logic              w_imem_req;
    logic              w_capture;
    logic              w_consume;
    logic [ADDR_W-1:0] w_next_pc;

    next_pc_calc u_next_pc_calc (
        .i_pc            (r_pc_out),
        .i_jump          (jump),
        .i_jump_imm      (jump_immediate),
        .i_branch_taken  (branch_taken),
        .i_branch_offset (branch_offset),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            FS_IDLE: begin
                w_state_nxt = FS_REQ;
            end
            FS_REQ: begin
                w_imem_req = 1'b1;
                if (imem.imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = FS_FILLED;
                end
            end
            FS_FILLED: begin
                if (!stall) begin
                    w_consume   = 1'b1;
                    w_state_nxt = FS_REQ;
                end
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    // Redirect inputs only matter through w_consume, i.e. in FILLED with no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_instruction <= '0;
            r_pc_out      <= '0;
            r_inst_valid  <= 1'b0;
        end else begin
            if (r_state == FS_IDLE) begin
                r_fetch_pc <= RESET_PC;
            end
            if (w_capture) begin
                r_instruction <= imem.imem_rdata;
                r_pc_out      <= r_fetch_pc;
                r_inst_valid  <= 1'b1;
            end
            if (w_consume) begin
                r_inst_valid <= 1'b0;
                r_fetch_pc   <= w_next_pc;
            end
        end
    end

    assign imem.imem_req  = w_imem_req;
    assign imem.imem_addr = r_fetch_pc;
    assign instruction    = r_instruction;
    assign pc_out         = r_pc_out;
    assign inst_valid     = r_inst_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations, then randomized traffic checked against a slot/pending model.
module tb_inst_fetch;

`ifdef INST_FETCH_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [25:0] jimm = '0;
    logic        bt = 1'b0;
    logic [15:0] boff = '0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        inst_valid;

    inst_fetch_if ifc ();

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (ifc),
        .instruction    (instruction),
        .inst_valid     (inst_valid),
        .pc_out         (pc_out),
        .stall          (stall),
        .jump           (jump),
        .jump_immediate (jimm),
        .branch_taken   (bt),
        .branch_offset  (boff)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int delay_cfg = 0;
    int wait_cnt  = 0;
    bit stray_en    = 1'b0;
    bit force_stray = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic j,
                                             input logic [25:0] ji, input logic b,
                                             input logic [15:0] bo);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(bo));
        if (j) return {seq[31:28], ji, 2'b00};
        if (BR_EN && b) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending fetch address and a one-word slot.
    bit          m_boot;
    bit          m_full;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot  <= 1'b1;
            m_full  <= 1'b0;
            m_instr <= '0;
            m_pc    <= '0;
            m_fetch <= RPC;
        end else if (m_boot) begin
            m_boot  <= 1'b0;
            m_fetch <= RPC;
        end else if (!m_full) begin
            if (ifc.imem_ack) begin
                m_full  <= 1'b1;
                m_instr <= ifc.imem_rdata;
                m_pc    <= m_fetch;
            end
        end else if (!stall) begin
            m_full  <= 1'b0;
            m_fetch <= ref_next(m_pc, jump, jimm, bt, boff);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_req", 32'(ifc.imem_req), 32'(!m_boot && !m_full));
            if (ifc.imem_req) chk("model_addr", ifc.imem_addr, m_fetch);
            chk("model_valid", 32'(inst_valid), 32'(m_full));
            chk("model_instr", instruction, m_instr);
            chk("model_pc", pc_out, m_pc);
        end
    end

    task automatic step(input bit s, input bit j, input logic [25:0] ji,
                        input bit b, input logic [15:0] bo);
        stall = s; jump = j; jimm = ji; bt = b; boff = bo;
        if (ifc.imem_req) begin
            if (wait_cnt >= delay_cfg) begin
                ifc.imem_ack   = 1'b1;
                ifc.imem_rdata = mem_word(ifc.imem_addr);
                wait_cnt       = 0;
            end else begin
                ifc.imem_ack   = 1'b0;
                ifc.imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            ifc.imem_ack   = force_stray || (stray_en && ($urandom_range(0, 3) == 0));
            ifc.imem_rdata = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bpc;
        logic [3:0]  kk;
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(ifc.imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_addr", ifc.imem_addr, RPC);

        rst_n = 1'b1;
        step(1, 0, '0, 0, '0);
        chk("first_req", 32'(ifc.imem_req), 32'd1);
        chk("first_addr", ifc.imem_addr, 32'h0);
        step(1, 0, '0, 0, '0);
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_instr", instruction, 32'h2001_0005);
        chk("first_pc", pc_out, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0, 0, '0);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_instr", instruction, 32'h2001_0005);
            chk("stall_pc", pc_out, 32'h0);
            chk("stall_req", 32'(ifc.imem_req), 32'd0);
        end
        step(0, 0, '0, 0, '0);
        chk("seq_req", 32'(ifc.imem_req), 32'd1);
        chk("seq_addr", ifc.imem_addr, 32'h4);
        chk("seq_valid", 32'(inst_valid), 32'd0);
        step(1, 0, '0, 0, '0);
        chk("fill4_pc", pc_out, 32'h4);

        step(0, 1, 26'h4, 0, '0);
        chk("jmp10_addr", ifc.imem_addr, 32'h10);
        step(1, 0, '0, 0, '0);
        chk("jmp10_pc", pc_out, 32'h10);
        step(0, 1, 26'h40, 0, '0);
        chk("jmp100_addr", ifc.imem_addr, 32'h100);
        chk("jmp100_model", m_fetch, 32'h100);
        step(1, 0, '0, 0, '0);
        step(0, 1, 26'h4, 0, '0);
        step(1, 0, '0, 0, '0);
        step(0, 1, 26'h40, 1, 16'h1234);
        chk("jmp_over_br_addr", ifc.imem_addr, 32'h100);

        step(1, 0, '0, 0, '0);
        step(0, 1, 26'h10, 0, '0);
        chk("jmp40_addr", ifc.imem_addr, 32'h40);
        step(1, 0, '0, 0, '0);
        chk("jmp40_pc", pc_out, 32'h40);
        step(0, 0, '0, 1, 16'hFFFE);
        bpc = BR_EN ? 32'h3C : 32'h44;
        chk("branch_addr", ifc.imem_addr, bpc);
        chk("branch_model", m_fetch, bpc);

        delay_cfg = 4;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0, 0, '0);
            chk("delay_req", 32'(ifc.imem_req), 32'd1);
            chk("delay_addr", ifc.imem_addr, bpc);
        end
        step(1, 0, '0, 0, '0);
        chk("delay_valid", 32'(inst_valid), 32'd1);
        chk("delay_pc", pc_out, bpc);
        delay_cfg = 0;

        force_stray = 1'b1;
        step(1, 0, '0, 0, '0);
        force_stray = 1'b0;
        chk("stray_instr", instruction, mem_word(bpc));
        chk("stray_pc", pc_out, bpc);
        chk("stray_req", 32'(ifc.imem_req), 32'd0);

        for (int k = 0; k < 16; k++) begin
            kk = k[3:0];
            step(0, 1, 26'h3FF_FFFF, 0, '0);
            chk("climb_addr", ifc.imem_addr, {kk, 28'hFFF_FFFC});
            step(1, 0, '0, 0, '0);
        end
        chk("top_pc", pc_out, 32'hFFFF_FFFC);
        step(0, 0, '0, 0, '0);
        chk("wrap_addr", ifc.imem_addr, 32'h0);
        step(1, 0, '0, 0, '0);
        chk("wrap_pc", pc_out, 32'h0);

        step(0, 0, '0, 0, '0);
        chk("prerst_addr", ifc.imem_addr, 32'h4);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'hCAFE_F00D;
        #2 rst_n = 1'b0;
        wait_cnt = 0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_instr", instruction, 32'd0);
        chk("midrst_req", 32'(ifc.imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        force_stray = 1'b1;
        step(1, 0, '0, 0, '0);
        force_stray = 1'b0;
        chk("restart_valid", 32'(inst_valid), 32'd0);
        chk("restart_req", 32'(ifc.imem_req), 32'd1);
        chk("restart_addr", ifc.imem_addr, RPC);
        step(1, 0, '0, 0, '0);
        chk("restart_instr", instruction, 32'h2001_0005);

        stray_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) delay_cfg = $urandom_range(0, 3);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                wait_cnt = 0;
                step(1, 0, '0, 0, '0);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 26'($urandom),
                 $urandom_range(0, 2) == 0, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; SHALL be word-aligned.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  byte address of the request; bits [1:0] always 0.
REQ-006 imem_ack  in  1  memory read response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  in  32  instruction word returned by memory.
REQ-008 instruction  out  32  IF/ID register contents driven to the decoder.
REQ-009 inst_valid  out  1  instruction holds a fetched, not-yet-consumed word.
REQ-010 pc_out  out  32  address of the word in instruction.
REQ-011 stall  in  1  downstream is not consuming instruction this cycle.
REQ-012 jump  in  1  decoded instruction is a jump.
REQ-013 jump_immediate  in  26  jump target field.
REQ-014 branch_taken  in  1  decoded beq resolved taken (active only with INST_FETCH_BRANCH_EN).
REQ-015 branch_offset  in  16  signed word offset of the branch.

Function
REQ-016 FSM states: IDLE, REQ, FILLED; encoded in 2 bits.
REQ-017 IDLE: imem_req=0; unconditional transition to REQ with fetch_pc=RESET_PC.
REQ-018 REQ: imem_req=1 and imem_addr=fetch_pc, both held stable until imem_ack=1.
REQ-019 REQ & imem_ack: on the same edge capture instruction<=imem_rdata and pc_out<=fetch_pc, set inst_valid<=1, go to FILLED; 1-cycle latency from ack to inst_valid.
REQ-020 FILLED: imem_req=0; instruction, pc_out and inst_valid held while stall=1.
REQ-021 FILLED & !stall: the word is consumed; clear inst_valid, load fetch_pc with next_pc, go to REQ.
REQ-022 next_pc: pc_out+4 by default; jump target = {pc4[31:28], jump_immediate, 2'b00}; branch target = pc4 + (sign_extend(branch_offset)<<2); pc4 = pc_out+4.
REQ-023 jump, branch_taken and the immediates SHALL be sampled only in FILLED & !stall; at all other times they are ignored.
REQ-024 jump and branch_taken asserted together: jump wins.
REQ-025 Address arithmetic is modulo 2^32: pc_out=32'hFFFF_FFFC with no redirect gives next_pc=32'h0000_0000.
REQ-026 imem_ack outside REQ SHALL be ignored: no capture and no state change.
REQ-027 At most one request is outstanding; no prefetch past the IF/ID slot, so a redirect never requires a flush.
REQ-028 Throughput is 1 instruction per 2 cycles minimum, reached when ack returns in the request cycle and stall=0.

Reset
REQ-029 rst_n low: state=IDLE, imem_req=0, inst_valid=0, instruction=0, pc_out=0, fetch_pc=RESET_PC, immediately and independent of clk.
REQ-030 Reset asserted mid-request abandons the request; an ack arriving while in reset or in the first IDLE cycle is dropped.
REQ-031 The first request after reset deassertion is issued on the second rising edge, at address RESET_PC.

Configuration
REQ-032 Macro INST_FETCH_BRANCH_EN defined: branch_taken/branch_offset redirect per REQ-022..024.
REQ-033 Macro undefined: branch_taken and branch_offset SHALL be ignored, and the branch target adder SHALL not be synthesised; jumps are unaffected.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the fetch-state enum, the RESET_PC default, and the 32-bit word/address width constants.
REQ-035 One sub-module, next_pc_calc, SHALL be purely combinational: pc_out, jump, jump_immediate, branch_taken and branch_offset in, next_pc out.

Verification
REQ-036 Reset with RESET_PC=0, memory acks in the request cycle with 0x20010005 -> imem_addr=0 on the 2nd edge; instruction=0x20010005, pc_out=0, inst_valid=1 one cycle later.
REQ-037 stall=1 for 3 cycles in FILLED -> instruction, pc_out and inst_valid unchanged; imem_req=0 throughout; next request at 0x4 the cycle after stall drops.
REQ-038 pc_out=0x0000_0010, jump=1, jump_immediate=0x0000040 -> next imem_addr=0x0000_0100; jump plus branch_taken together -> still 0x0000_0100.
REQ-039 INST_FETCH_BRANCH_EN defined, pc_out=0x40, branch_taken=1, offset=16'hFFFE -> imem_addr=0x3C; macro undefined, same stimulus -> 0x44.
REQ-040 ack delayed 4 cycles -> imem_addr stable and imem_req high for 5 cycles; a stray ack in FILLED causes no change; pc_out=0xFFFF_FFFC wraps to 0x0.
REQ-041 rst_n pulsed low while in REQ with ack in the same cycle -> inst_valid=0 and no capture; fetch restarts at RESET_PC.
